// File: rtl/i2c_slave.sv
// I2C target: oversampled sclk/sda with 2-flop synchronizers, LSB-first framing,
// single-byte address compare, unbounded multi-byte reads and writes.
module i2c_slave #(
  parameter logic [7:0] SLAVE_ADDRESS = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       sda_in,
  output logic       sda_out,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_load,
  output logic       busy,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    RX        = 3'd3,
    RX_ACK    = 3'd4,
    TX        = 3'd5,
    TX_ACK    = 3'd6,
    WAIT_STOP = 3'd7
  } state_t;

  state_t     r_state;
  logic [1:0] r_sclk_sync;
  logic [1:0] r_sda_sync;
  logic       r_sclk_prev;
  logic       r_sda_prev;
  logic [3:0] r_cnt;
  logic [7:0] r_shift;
  logic [7:0] r_tx;
  logic       r_rw;
  logic       r_bit9;
  logic       r_sda_out;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_tx_load;
  logic       r_busy;

  logic w_sclk;
  logic w_sda;
  logic w_rise;
  logic w_fall;
  logic w_start;
  logic w_stop;

  assign w_sclk  = r_sclk_sync[1];
  assign w_sda   = r_sda_sync[1];
  assign w_rise  = w_sclk & ~r_sclk_prev;
  assign w_fall  = ~w_sclk & r_sclk_prev;
  // Requiring sclk high in both samples keeps a simultaneous sda/sclk change as data.
  assign w_start = w_sclk & r_sclk_prev & r_sda_prev & ~w_sda;
  assign w_stop  = w_sclk & r_sclk_prev & ~r_sda_prev & w_sda;

  assign sda_out  = r_sda_out;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign tx_load  = r_tx_load;
  assign busy     = r_busy;
  assign state    = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_sync <= 2'b11;
      r_sda_sync  <= 2'b11;
      r_sclk_prev <= 1'b1;
      r_sda_prev  <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[0], sclk};
      r_sda_sync  <= {r_sda_sync[0], sda_in};
      r_sclk_prev <= r_sclk_sync[1];
      r_sda_prev  <= r_sda_sync[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_shift    <= 8'h00;
      r_tx       <= 8'h00;
      r_rw       <= 1'b0;
      r_bit9     <= 1'b0;
      r_sda_out  <= 1'b1;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_tx_load  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_tx_load  <= 1'b0;
      if (w_stop) begin
        r_state   <= IDLE;
        r_cnt     <= 4'd0;
        r_bit9    <= 1'b0;
        r_sda_out <= 1'b1;
        r_busy    <= 1'b0;
      end else if (w_start) begin
        r_state   <= ADDR;
        r_cnt     <= 4'd0;
        r_bit9    <= 1'b0;
        r_sda_out <= 1'b1;
        r_busy    <= 1'b1;
      end else begin
        case (r_state)
          IDLE: r_sda_out <= 1'b1;
          ADDR: begin
            // Counter stops at 8; the 9th (R/W) bit is flagged separately.
            if (w_rise) begin
              if (r_cnt == 4'd8) begin
                r_rw   <= w_sda;
                r_bit9 <= 1'b1;
              end else begin
                r_shift <= {w_sda, r_shift[7:1]};
                r_cnt   <= r_cnt + 4'd1;
              end
            end else if (w_fall && r_bit9) begin
              r_bit9 <= 1'b0;
              r_cnt  <= 4'd0;
              if (r_shift == SLAVE_ADDRESS) begin
                r_sda_out <= 1'b0;
                r_state   <= ADDR_ACK;
              end else begin
                r_sda_out <= 1'b1;
                r_state   <= WAIT_STOP;
              end
            end
          end
          ADDR_ACK: begin
            if (w_fall) begin
              if (!r_rw) begin
                r_sda_out <= 1'b1;
                r_cnt     <= 4'd0;
                r_state   <= RX;
              end else begin
                r_tx      <= tx_data;
                r_tx_load <= 1'b1;
                r_sda_out <= tx_data[0];
                r_cnt     <= 4'd1;
                r_state   <= TX;
              end
            end
          end
          RX: begin
            if (w_rise && r_cnt < 4'd8) begin
              r_shift <= {w_sda, r_shift[7:1]};
              r_cnt   <= r_cnt + 4'd1;
              if (r_cnt == 4'd7) begin
                r_rx_data  <= {w_sda, r_shift[7:1]};
                r_rx_valid <= 1'b1;
              end
            end else if (w_fall && r_cnt == 4'd8) begin
              r_sda_out <= 1'b0;
              r_cnt     <= 4'd0;
              r_state   <= RX_ACK;
            end
          end
          RX_ACK: begin
            if (w_fall) begin
              r_sda_out <= 1'b1;
              r_cnt     <= 4'd0;
              r_state   <= RX;
            end
          end
          TX: begin
            if (w_fall) begin
              if (r_cnt == 4'd8) begin
                r_sda_out <= 1'b1;
                r_cnt     <= 4'd0;
                r_state   <= TX_ACK;
              end else begin
                r_sda_out <= r_tx[r_cnt[2:0]];
                r_cnt     <= r_cnt + 4'd1;
              end
            end
          end
          TX_ACK: begin
            // r_cnt==1 marks a sampled master ACK awaiting the next falling edge.
            if (w_rise) begin
              if (w_sda) r_state <= WAIT_STOP;
              else       r_cnt   <= 4'd1;
            end else if (w_fall && r_cnt == 4'd1) begin
              r_tx      <= tx_data;
              r_tx_load <= 1'b1;
              r_sda_out <= tx_data[0];
              r_cnt     <= 4'd1;
              r_state   <= TX;
            end
          end
          default: r_sda_out <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bus master model on a wired-AND sda line,
// with scoreboard queues for bytes the slave receives and bytes it returns.
module tb_i2c_slave;

  localparam int QP = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sclk = 1'b1;
  logic       m_sda = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       sda_out;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_load;
  logic       busy;
  logic [2:0] state;
  logic       sda_bus;

  assign sda_bus = m_sda & sda_out;

  always #5 clk = ~clk;

  i2c_slave #(.SLAVE_ADDRESS(8'hA5)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .sda_in(sda_bus), .sda_out(sda_out),
    .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid), .tx_load(tx_load),
    .busy(busy), .state(state)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] q_rx[$];
  logic [7:0] q_tx[$];

  int   rv_cyc = 0, rv_pulses = 0, tl_cyc = 0, tl_pulses = 0, low_cyc = 0;
  logic rv_d = 1'b0, tl_d = 1'b0;

  always @(posedge clk) begin
    rv_d <= rx_valid;
    tl_d <= tx_load;
    if (rx_valid === 1'b1) rv_cyc <= rv_cyc + 1;
    if (rx_valid === 1'b1 && rv_d !== 1'b1) rv_pulses <= rv_pulses + 1;
    if (tx_load === 1'b1) tl_cyc <= tl_cyc + 1;
    if (tx_load === 1'b1 && tl_d !== 1'b1) tl_pulses <= tl_pulses + 1;
    if (sda_out === 1'b0) low_cyc <= low_cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Received-byte scoreboard: popped whenever the DUT flags a new byte.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      chk("rx_queue_nonempty", {31'd0, q_rx.size() > 0}, 32'd1);
      if (q_rx.size() > 0) chk("rx_data", {24'd0, rx_data}, {24'd0, q_rx.pop_front()});
    end
  end

  task automatic hp();
    repeat (QP) @(posedge clk);
    #1;
  endtask

  task automatic start_c();
    m_sda = 1'b1; hp();
    sclk  = 1'b1; hp();
    m_sda = 1'b0; hp();
    sclk  = 1'b0; hp();
  endtask

  task automatic stop_c();
    m_sda = 1'b0; hp();
    sclk  = 1'b1; hp();
    m_sda = 1'b1; hp();
  endtask

  task automatic wbit(input logic b);
    m_sda = b;    hp();
    sclk  = 1'b1; hp();
    sclk  = 1'b0; hp();
  endtask

  task automatic rbit(output logic b);
    m_sda = 1'b1; hp();
    sclk  = 1'b1; hp();
    b = sda_bus;
    sclk  = 1'b0; hp();
  endtask

  task automatic wbyte(input logic [7:0] d);
    for (int i = 0; i < 8; i++) wbit(d[i]);
  endtask

  task automatic rbyte(input string tag);
    logic [7:0] d;
    logic b;
    for (int i = 0; i < 8; i++) begin
      rbit(b);
      d[i] = b;
    end
    chk({tag, "_queued"}, {31'd0, q_tx.size() > 0}, 32'd1);
    if (q_tx.size() > 0) chk(tag, {24'd0, d}, {24'd0, q_tx.pop_front()});
  endtask

  task automatic addr_phase(input string tag, input logic [7:0] a, input logic rw,
                            input logic exp_ack);
    logic ack;
    start_c();
    chk({tag, "_state_addr"}, {29'd0, state}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    wbyte(a);
    wbit(rw);
    rbit(ack);
    chk(tag, {31'd0, ack}, {31'd0, exp_ack});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   rv0, rvc0, tl0, tlc0, low0;
    logic ack;

    // Asynchronous reset, checked before the first clock edge.
    #2 rst = 1'b1;
    #1;
    chk("rst_state",    {29'd0, state},    32'd0);
    chk("rst_sda_out",  {31'd0, sda_out},  32'd1);
    chk("rst_rx_data",  {24'd0, rx_data},  32'd0);
    chk("rst_busy",     {31'd0, busy},     32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_tx_load",  {31'd0, tx_load},  32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    hp();

    // Single-byte write of 0x3C.
    rv0 = rv_pulses; rvc0 = rv_cyc;
    addr_phase("w_addr_ack", 8'hA5, 1'b0, 1'b0);
    q_rx.push_back(8'h3C);
    wbyte(8'h3C);
    rbit(ack);
    chk("w_data_ack", {31'd0, ack}, 32'd0);
    stop_c();
    chk("w_state_idle", {29'd0, state}, 32'd0);
    chk("w_busy_clear", {31'd0, busy}, 32'd0);
    chk("w_rx_data_hold", {24'd0, rx_data}, 32'h3C);
    chk("w_rx_valid_pulses", rv_pulses - rv0, 32'd1);
    chk("w_rx_valid_cycles", rv_cyc - rvc0, 32'd1);

    // Single-byte read of 0x96 ending in NACK.
    tx_data = 8'h96;
    tl0 = tl_pulses; tlc0 = tl_cyc;
    q_tx.push_back(8'h96);
    addr_phase("r_addr_ack", 8'hA5, 1'b1, 1'b0);
    rbyte("r_byte");
    wbit(1'b1);
    chk("r_state_wait_stop", {29'd0, state}, 32'd7);
    stop_c();
    chk("r_state_idle", {29'd0, state}, 32'd0);
    chk("r_tx_load_pulses", tl_pulses - tl0, 32'd1);
    chk("r_tx_load_cycles", tl_cyc - tlc0, 32'd1);

    // Address mismatch: slave must never pull sda low.
    rv0 = rv_pulses; tl0 = tl_pulses; low0 = low_cyc;
    addr_phase("m_ack_released", 8'h5A, 1'b0, 1'b1);
    wbyte(8'h00);
    chk("m_state_wait_stop", {29'd0, state}, 32'd7);
    stop_c();
    chk("m_state_idle", {29'd0, state}, 32'd0);
    chk("m_sda_never_low", low_cyc - low0, 32'd0);
    chk("m_no_rx_valid", rv_pulses - rv0, 32'd0);
    chk("m_no_tx_load", tl_pulses - tl0, 32'd0);

    // Two-byte read: ACK after 0x11, NACK after 0x22.
    tx_data = 8'h11;
    tl0 = tl_pulses; tlc0 = tl_cyc;
    q_tx.push_back(8'h11);
    q_tx.push_back(8'h22);
    addr_phase("mb_addr_ack", 8'hA5, 1'b1, 1'b0);
    rbyte("mb_byte0");
    tx_data = 8'h22;
    wbit(1'b0);
    rbyte("mb_byte1");
    wbit(1'b1);
    stop_c();
    chk("mb_state_idle", {29'd0, state}, 32'd0);
    chk("mb_tx_load_pulses", tl_pulses - tl0, 32'd2);
    chk("mb_tx_load_cycles", tl_cyc - tlc0, 32'd2);

    // Write address, repeated start, then read 0xF0.
    tx_data = 8'hF0;
    addr_phase("rs_w_addr_ack", 8'hA5, 1'b0, 1'b0);
    q_tx.push_back(8'hF0);
    addr_phase("rs_r_addr_ack", 8'hA5, 1'b1, 1'b0);
    rbyte("rs_byte");
    wbit(1'b1);
    stop_c();
    chk("rs_state_idle", {29'd0, state}, 32'd0);

    // Reset during the 4th data bit of a write, then a clean write of 0x7E.
    addr_phase("rst_addr_ack", 8'hA5, 1'b0, 1'b0);
    wbit(1'b1); wbit(1'b1); wbit(1'b0);
    m_sda = 1'b1; hp();
    sclk  = 1'b1; hp();
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_sda_out", {31'd0, sda_out}, 32'd1);
    chk("mid_rst_rx_data", {24'd0, rx_data}, 32'd0);
    chk("mid_rst_state",   {29'd0, state},   32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sclk = 1'b0; hp();
    wbit(1'b0); wbit(1'b1);
    chk("post_rst_still_idle", {29'd0, state}, 32'd0);
    rv0 = rv_pulses;
    addr_phase("post_rst_addr_ack", 8'hA5, 1'b0, 1'b0);
    q_rx.push_back(8'h7E);
    wbyte(8'h7E);
    rbit(ack);
    chk("post_rst_data_ack", {31'd0, ack}, 32'd0);
    stop_c();
    chk("post_rst_rx_data", {24'd0, rx_data}, 32'h7E);
    chk("post_rst_rx_valid", rv_pulses - rv0, 32'd1);
    chk("rx_queue_drained", q_rx.size(), 32'd0);
    chk("tx_queue_drained", q_tx.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL have parameter SLAVE_ADDRESS, default 8'hA5, the 8-bit address this target answers to.
REQ-002 SHALL have port clk  input  1  internal clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port sclk  input  1  serial clock from bus master.
REQ-005 SHALL have port sda_in  input  1  serial data as seen on bus.
REQ-006 SHALL have port sda_out  output  1  serial data drive; 1 = released, 0 = pull low.
REQ-007 SHALL have port tx_data  input  8  byte returned to master on reads.
REQ-008 SHALL have port rx_data  output  8  last byte received on writes.
REQ-009 SHALL have port rx_valid  output  1  one-clk pulse when rx_data updates.
REQ-010 SHALL have port tx_load  output  1  one-clk pulse when tx_data is latched.
REQ-011 SHALL have port busy  output  1  high from start detection until stop or abort.
REQ-012 SHALL have port state  output  3  current FSM state, debug only.

Function
REQ-013 SHALL pass sclk and sda_in through 2-flop synchronizers; edges detected by comparing current to previous synchronized sample (3 clk latency from pin to detection).
REQ-014 SHALL detect start as synced sda 1->0 while synced sclk is 1 in both current and previous sample; stop as sda 0->1 under the same sclk condition.
REQ-015 SHALL treat an sda change in the same sample as an sclk change as data, never start/stop.
REQ-016 SHALL sample sda on detected sclk rising edges and change sda_out only on detected sclk falling edges.
REQ-017 SHALL shift all fields LSB first: 8 address bits, then 1 R/W bit (1 = read), then ACK, then 8-bit data bytes each followed by ACK.
REQ-018 SHALL implement states IDLE=0, ADDR=1, ADDR_ACK=2, RX=3, RX_ACK=4, TX=5, TX_ACK=6, WAIT_STOP=7.
REQ-019 IDLE: sda_out=1, busy=0; start -> ADDR, bit counter cleared.
REQ-020 ADDR: collect 9 bits; on falling edge after 9th bit, if address == SLAVE_ADDRESS drive sda_out=0 and enter ADDR_ACK, else enter WAIT_STOP with sda_out=1.
REQ-021 ADDR_ACK: hold sda_out=0 through ACK clock; on the next falling edge, R/W=0 -> release sda, enter RX; R/W=1 -> latch tx_data, pulse tx_load, drive bit 0, enter TX.
REQ-022 RX: on 8th sampled bit update rx_data and pulse rx_valid in that same clk; on following falling edge drive sda_out=0, enter RX_ACK.
REQ-023 RX_ACK: on next falling edge release sda, clear counter, return to RX (multi-byte writes unbounded).
REQ-024 TX: drive bits 1..7 on successive falling edges; on falling edge after bit 7 release sda, enter TX_ACK.
REQ-025 TX_ACK: sample master ACK on rising edge; 0 -> on next falling edge latch tx_data, pulse tx_load, drive bit 0, enter TX; 1 (NACK) -> enter WAIT_STOP.
REQ-026 WAIT_STOP: sda_out=1, ignore data; wait for stop or start.
REQ-027 Stop in any state SHALL enter IDLE and release sda within 1 clk of detection.
REQ-028 Start in any non-IDLE state (repeated start) SHALL enter ADDR, clear counter, release sda.
REQ-029 Bit counter SHALL be 4 bits, wrap to 0 on every byte/ACK boundary; never exceed 8.
REQ-030 rx_valid and tx_load SHALL never be high for more than 1 consecutive clk.

Reset
REQ-031 rst high SHALL immediately force: state=IDLE, sda_out=1, rx_data=8'h00, rx_valid=0, tx_load=0, busy=0, counter=0, synchronizers to 1.
REQ-032 Reset asserted mid-transfer SHALL release sda without waiting for a clk edge; after release, slave waits for a fresh start.

Verification
REQ-033 Write: start, addr 8'hA5 LSB first, R/W=0, data 8'h3C -> ACK low in address and data ACK slots, rx_data=8'h3C, exactly one rx_valid pulse.
REQ-034 Read: start, addr 8'hA5, R/W=1, tx_data=8'h96, master NACK -> sda carries 0,1,1,0,1,0,0,1, one tx_load pulse, state WAIT_STOP, then IDLE on stop.
REQ-035 Mismatch: start, addr 8'h5A -> sda_out stays 1 throughout, no rx_valid/tx_load, IDLE after stop.
REQ-036 Multi-byte read 8'h11 then 8'h22 with master ACK then NACK -> two tx_load pulses, both bytes correct.
REQ-037 Repeated start after write address ACK, then read of 8'hF0 -> state returns to ADDR, read completes correctly.
REQ-038 rst pulsed during 4th bit of write data -> sda_out=1 same instant, rx_data=8'h00, later full write of 8'h7E succeeds.
